// File: rtl/mbist_response_checker.sv
// MBIST read-side response checker: compares read-back data against the expected background and accumulates pass/fail statistics.
// Optional first-fail diagnostics are enabled by defining MBIST_CHECKER_DIAG_EN.
`timescale 1ns/1ps
module mbist_response_checker #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        q,
    input  logic              rd_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    input  logic              end_test,
    output logic              busy,
    output logic              result_valid,
    output logic              fail,
    output logic              pattern_err,
    output logic [CNT_W-1:0]  fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic [DATA_W-1:0] first_fail_syn
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns {code_valid, expected_byte} for a pattern code.
    function automatic logic [8:0] decode_pattern(input logic [2:0] code);
        case (code)
            3'b000:  decode_pattern = {1'b1, 8'hAA};
            3'b001:  decode_pattern = {1'b1, 8'h55};
            3'b010:  decode_pattern = {1'b1, 8'hF0};
            3'b011:  decode_pattern = {1'b1, 8'h0F};
            3'b100:  decode_pattern = {1'b1, 8'h00};
            3'b101:  decode_pattern = {1'b1, 8'hFF};
            default: decode_pattern = {1'b0, 8'h00};
        endcase
    endfunction

    state_t            state_r;
    logic              busy_r;
    logic              result_valid_r;
    logic              s1_valid_r;
    logic              s1_inv_r;
    logic [ADDR_W-1:0] s1_addr_r;
    logic [DATA_W-1:0] s1_data_r;
    logic [DATA_W-1:0] s1_exp_r;
    logic              fail_r;
    logic              pattern_err_r;
    logic [CNT_W-1:0]  fail_count_r;

    logic [8:0]        dec_s;
    logic              accept_s;
    logic [DATA_W-1:0] exp_s;
    logic [DATA_W-1:0] syn_s;
    logic              mismatch_s;
    logic              cnt_max_s;

    assign dec_s      = decode_pattern(q);
    assign accept_s   = rd_valid && (state_r == ST_RUN) && !start;
    assign exp_s      = {(DATA_W/8){dec_s[7:0]}};
    assign syn_s      = s1_data_r ^ s1_exp_r;
    assign mismatch_s = |syn_s;
    assign cnt_max_s  = (fail_count_r == {CNT_W{1'b1}});

    // Control FSM; busy/result_valid are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else if (start) begin
            state_r        <= ST_RUN;
            busy_r         <= 1'b1;
            result_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (end_test) begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    state_r        <= ST_DONE;
                    busy_r         <= 1'b0;
                    result_valid_r <= 1'b1;
                end
                ST_IDLE, ST_DONE: begin
                    state_r <= state_r;
                end
                default: begin
                    state_r        <= ST_IDLE;
                    busy_r         <= 1'b0;
                    result_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // Stage 1: capture the beat and its expected word; start discards any beat in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_inv_r   <= 1'b0;
            s1_addr_r  <= {ADDR_W{1'b0}};
            s1_data_r  <= {DATA_W{1'b0}};
            s1_exp_r   <= {DATA_W{1'b0}};
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_inv_r  <= !dec_s[8];
                s1_addr_r <= rd_addr;
                s1_data_r <= rd_data;
                s1_exp_r  <= exp_s;
            end
        end
    end

    // Stage 2: sticky flags and saturating mismatch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_r        <= 1'b0;
            pattern_err_r <= 1'b0;
            fail_count_r  <= {CNT_W{1'b0}};
        end else if (start) begin
            fail_r        <= 1'b0;
            pattern_err_r <= 1'b0;
            fail_count_r  <= {CNT_W{1'b0}};
        end else if (s1_valid_r) begin
            if (s1_inv_r) begin
                pattern_err_r <= 1'b1;
            end else if (mismatch_s) begin
                fail_r <= 1'b1;
                if (!cnt_max_s) begin
                    fail_count_r <= fail_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

`ifdef MBIST_CHECKER_DIAG_EN
    logic [ADDR_W-1:0] ff_addr_r;
    logic [DATA_W-1:0] ff_syn_r;

    // First-fail capture: loads only while fail is still clear, so it freezes after the first mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff_addr_r <= {ADDR_W{1'b0}};
            ff_syn_r  <= {DATA_W{1'b0}};
        end else if (start) begin
            ff_addr_r <= {ADDR_W{1'b0}};
            ff_syn_r  <= {DATA_W{1'b0}};
        end else if (s1_valid_r && !s1_inv_r && mismatch_s && !fail_r) begin
            ff_addr_r <= s1_addr_r;
            ff_syn_r  <= syn_s;
        end
    end

    assign first_fail_addr = ff_addr_r;
    assign first_fail_syn  = ff_syn_r;
`else
    logic [ADDR_W-1:0] unused_addr_s;

    assign unused_addr_s   = s1_addr_r;
    assign first_fail_addr = {ADDR_W{1'b0}};
    assign first_fail_syn  = {DATA_W{1'b0}};
`endif

    assign busy         = busy_r;
    assign result_valid = result_valid_r;
    assign fail         = fail_r;
    assign pattern_err  = pattern_err_r;
    assign fail_count   = fail_count_r;

endmodule
